// File: rtl/pipeline_sequencer_if.sv
// Control/status bundle between the hazard-detection logic and the pipeline sequencer.
// master drives the hazard/event inputs; slave (the sequencer) drives enables, flushes and counters.
interface pipeline_sequencer_if #(
  parameter int unsigned CNT_W = 16
);
  logic             load_use_hazard;
  logic             branch_taken;
  logic             mem_busy;
  logic             halt_req;
  logic             cnt_clear;
  logic             pc_en;
  logic             fd_en;
  logic             de_en;
  logic             em_en;
  logic             mw_en;
  logic             fd_flush;
  logic             de_flush;
  logic             halted;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_events;

  modport master (
    output load_use_hazard, branch_taken, mem_busy, halt_req, cnt_clear,
    input  pc_en, fd_en, de_en, em_en, mw_en, fd_flush, de_flush, halted,
    input  stall_cycles, flush_events
  );

  modport slave (
    input  load_use_hazard, branch_taken, mem_busy, halt_req, cnt_clear,
    output pc_en, fd_en, de_en, em_en, mw_en, fd_flush, de_flush, halted,
    output stall_cycles, flush_events
  );
endinterface

// File: rtl/pipeline_sequencer.sv
// Five-stage pipeline sequencer: stage enables and flushes for load-use stalls,
// taken-branch flushes, memory freezes and halt, plus saturating performance counters.
module pipeline_sequencer #(
  parameter int unsigned STALL_CYCLES = 1,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 16
) (
  input logic                 clk,
  input logic                 rst,
  pipeline_sequencer_if.slave bus
);

  typedef enum logic [1:0] {StRun, StStall, StFlush, StHalt} state_e;

  localparam logic [2:0] StallRem = 3'(STALL_CYCLES - 1);
  localparam logic [2:0] FlushRem = 3'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  state_e           state_q, state_d;
  logic [2:0]       rem_q, rem_d;
  logic [CNT_W-1:0] stall_q, flush_q;

  logic pc_en, fd_en, de_en, em_en, mw_en, fd_flush, de_flush, halted;
  logic flush_inc, stall_inc;

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    pc_en     = 1'b1;
    fd_en     = 1'b1;
    de_en     = 1'b1;
    em_en     = 1'b1;
    mw_en     = 1'b1;
    fd_flush  = 1'b0;
    de_flush  = 1'b0;
    halted    = 1'b0;
    flush_inc = 1'b0;

    if (state_q == StHalt) begin
      {pc_en, fd_en, de_en, em_en, mw_en} = '0;
      halted = 1'b1;
    end else if (bus.halt_req) begin
      {pc_en, fd_en, de_en, em_en, mw_en} = '0;
      state_d = StHalt;
      rem_d   = '0;
    end else if (bus.mem_busy) begin
      // Freeze: state and rem hold by default.
      {pc_en, fd_en, de_en, em_en, mw_en} = '0;
    end else if (bus.branch_taken) begin
      fd_flush  = 1'b1;
      de_flush  = 1'b1;
      flush_inc = 1'b1;
      if (FLUSH_CYCLES > 1) begin
        state_d = StFlush;
        rem_d   = FlushRem;
      end else begin
        state_d = StRun;
        rem_d   = '0;
      end
    end else begin
      unique case (state_q)
        StFlush: begin
          fd_flush = 1'b1;
          rem_d    = (rem_q <= 3'd1) ? 3'd0 : rem_q - 3'd1;
          if (rem_q <= 3'd1) state_d = StRun;
        end
        StStall: begin
          pc_en    = 1'b0;
          fd_en    = 1'b0;
          de_flush = 1'b1;
          rem_d    = (rem_q <= 3'd1) ? 3'd0 : rem_q - 3'd1;
          if (rem_q <= 3'd1) state_d = StRun;
        end
        StRun: begin
          if (bus.load_use_hazard) begin
            pc_en    = 1'b0;
            fd_en    = 1'b0;
            de_flush = 1'b1;
            if (STALL_CYCLES > 1) begin
              state_d = StStall;
              rem_d   = StallRem;
            end
          end
        end
        default: ;
      endcase
    end

    // Mealy RUN outputs would otherwise leak input activity while reset is held.
    if (!rst) begin
      {pc_en, fd_en, de_en, em_en, mw_en} = '1;
      fd_flush  = 1'b0;
      de_flush  = 1'b0;
      halted    = 1'b0;
      flush_inc = 1'b0;
    end
  end

  assign stall_inc = !pc_en && (state_q != StHalt);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StRun;
      rem_q   <= '0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      if (bus.cnt_clear)                       stall_q <= '0;
      else if (stall_inc && stall_q != CntMax) stall_q <= stall_q + 1'b1;
      if (bus.cnt_clear)                       flush_q <= '0;
      else if (flush_inc && flush_q != CntMax) flush_q <= flush_q + 1'b1;
    end
  end

  assign bus.pc_en        = pc_en;
  assign bus.fd_en        = fd_en;
  assign bus.de_en        = de_en;
  assign bus.em_en        = em_en;
  assign bus.mw_en        = mw_en;
  assign bus.fd_flush     = fd_flush;
  assign bus.de_flush     = de_flush;
  assign bus.halted       = halted;
  assign bus.stall_cycles = stall_q;
  assign bus.flush_events = flush_q;

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Scoreboard bench: two sequencer configurations share one random/directed stimulus stream and
// are checked against a remaining-cycle-count reference model.
module tb_pipeline_sequencer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipeline_sequencer_if #(.CNT_W(4))  bus_a ();
  pipeline_sequencer_if #(.CNT_W(16)) bus_b ();

  pipeline_sequencer #(.STALL_CYCLES(1), .FLUSH_CYCLES(2), .CNT_W(4)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  pipeline_sequencer #(.STALL_CYCLES(3), .FLUSH_CYCLES(1), .CNT_W(16)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  typedef struct {
    int         dut;
    int         cyc;
    logic [7:0] outs;   // {pc,fd,de,em,mw,fd_flush,de_flush,halted}
    int         scnt;
    int         fcnt;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  // Reference model: remaining stall/flush cycles and counters per configuration.
  int stall_len[2] = '{1, 3};
  int flush_len[2] = '{2, 1};
  int cnt_max[2]   = '{15, 65535};
  int m_halted[2], m_stall_left[2], m_flush_left[2], m_scnt[2], m_fcnt[2];

  function automatic logic [7:0] dut_outs(input int d);
    if (d == 0)
      return {bus_a.pc_en, bus_a.fd_en, bus_a.de_en, bus_a.em_en, bus_a.mw_en,
              bus_a.fd_flush, bus_a.de_flush, bus_a.halted};
    return {bus_b.pc_en, bus_b.fd_en, bus_b.de_en, bus_b.em_en, bus_b.mw_en,
            bus_b.fd_flush, bus_b.de_flush, bus_b.halted};
  endfunction

  function automatic int dut_scnt(input int d);
    return (d == 0) ? int'(bus_a.stall_cycles) : int'(bus_b.stall_cycles);
  endfunction

  function automatic int dut_fcnt(input int d);
    return (d == 0) ? int'(bus_a.flush_events) : int'(bus_b.flush_events);
  endfunction

  task automatic model_step(input int d, input logic r, input logic luh, input logic br,
                            input logic mb, input logic hr, input logic cc);
    exp_t e;
    logic pc, fd, de, em, mw, ff, df, h;
    logic was_halted, bump;
    e.dut = d;
    e.cyc = cyc;
    if (!r) begin
      m_halted[d] = 0; m_stall_left[d] = 0; m_flush_left[d] = 0;
      m_scnt[d] = 0; m_fcnt[d] = 0;
      e.outs = 8'b11111000;
      e.scnt = 0;
      e.fcnt = 0;
      sb.push_back(e);
      return;
    end
    {pc, fd, de, em, mw} = 5'b11111;
    {ff, df, h} = 3'b000;
    bump = 1'b0;
    was_halted = (m_halted[d] != 0);
    if (was_halted) begin
      {pc, fd, de, em, mw} = 5'b0;
      h = 1'b1;
    end else if (hr) begin
      {pc, fd, de, em, mw} = 5'b0;
      m_halted[d] = 1;
    end else if (mb) begin
      {pc, fd, de, em, mw} = 5'b0;
    end else if (br) begin
      ff = 1'b1; df = 1'b1; bump = 1'b1;
      m_flush_left[d] = flush_len[d] - 1;
      m_stall_left[d] = 0;
    end else if (m_flush_left[d] > 0) begin
      ff = 1'b1;
      m_flush_left[d]--;
    end else if (m_stall_left[d] > 0) begin
      pc = 1'b0; fd = 1'b0; df = 1'b1;
      m_stall_left[d]--;
    end else if (luh) begin
      pc = 1'b0; fd = 1'b0; df = 1'b1;
      m_stall_left[d] = stall_len[d] - 1;
    end
    e.outs = {pc, fd, de, em, mw, ff, df, h};
    e.scnt = m_scnt[d];
    e.fcnt = m_fcnt[d];
    sb.push_back(e);
    if (cc) m_scnt[d] = 0;
    else if (!pc && !was_halted && m_scnt[d] < cnt_max[d]) m_scnt[d]++;
    if (cc) m_fcnt[d] = 0;
    else if (bump && m_fcnt[d] < cnt_max[d]) m_fcnt[d]++;
  endtask

  // One clock cycle of stimulus: drive just after the rising edge, then queue expectations.
  task automatic cycle(input logic r, input logic luh, input logic br, input logic mb,
                       input logic hr, input logic cc);
    @(posedge clk);
    #1;
    rst = r;
    bus_a.load_use_hazard = luh; bus_b.load_use_hazard = luh;
    bus_a.branch_taken    = br;  bus_b.branch_taken    = br;
    bus_a.mem_busy        = mb;  bus_b.mem_busy        = mb;
    bus_a.halt_req        = hr;  bus_b.halt_req        = hr;
    bus_a.cnt_clear       = cc;  bus_b.cnt_clear       = cc;
    cyc++;
    for (int d = 0; d < 2; d++) model_step(d, r, luh, br, mb, hr, cc);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: outputs are settled mid-cycle, so compare on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        n_cmp++;
        if (dut_outs(e.dut) !== e.outs) begin
          n_bad++;
          $display("FAIL outputs dut%0d cycle %0d: got %b expected %b",
                   e.dut, e.cyc, dut_outs(e.dut), e.outs);
        end
        n_cmp++;
        if (dut_scnt(e.dut) != e.scnt) begin
          n_bad++;
          $display("FAIL stall_cycles dut%0d cycle %0d: got %0d expected %0d",
                   e.dut, e.cyc, dut_scnt(e.dut), e.scnt);
        end
        n_cmp++;
        if (dut_fcnt(e.dut) != e.fcnt) begin
          n_bad++;
          $display("FAIL flush_events dut%0d cycle %0d: got %0d expected %0d",
                   e.dut, e.cyc, dut_fcnt(e.dut), e.fcnt);
        end
      end
    end
  end

  initial begin
    rst = 1'b0;
    {bus_a.load_use_hazard, bus_a.branch_taken, bus_a.mem_busy, bus_a.halt_req,
     bus_a.cnt_clear} = '0;
    {bus_b.load_use_hazard, bus_b.branch_taken, bus_b.mem_busy, bus_b.halt_req,
     bus_b.cnt_clear} = '0;

    // Reset with busy inputs: outputs must still be the RUN defaults.
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    idle(2);

    // Single load-use hazard.
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(4);

    // Single taken branch.
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(3);

    // Branch and hazard together: branch wins.
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(3);

    // Memory freeze inside a flush.
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(3);

    // Freeze inside a stall (exercises STALL_CYCLES=3 configuration).
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(4);

    // Counter saturation and clear-versus-increment.
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(3);

    // Halt then reset out of it.
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++)
      cycle(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(3);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      cycle(1'($urandom_range(0, 99) != 0), 1'($urandom_range(0, 3) == 0),
            1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 5) == 0),
            1'($urandom_range(0, 79) == 0), 1'($urandom_range(0, 39) == 0));
    end
    idle(2);

    @(negedge clk);
    #1;
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
